// File: rtl/patch_fetch.sv
// Feeds the age stage one event at a time: reads the event's (2R+1)^2 neighbourhood
// two pixels per beat from the time-surface memory, then writes {ts,pol} back to the centre.
module patch_fetch #(
    parameter int TIMESTAMP_BITS = 16,
    parameter int POLARITY_BITS  = 2,
    parameter int WORD_SIZE      = 18,
    parameter int X_BITS         = 5,
    parameter int Y_BITS         = 5,
    parameter int RADIUS         = 2,
    parameter int TAU            = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic [X_BITS-1:0]         ev_x,
    input  logic [Y_BITS-1:0]         ev_y,
    input  logic [TIMESTAMP_BITS-1:0] ev_ts,
    input  logic [POLARITY_BITS-1:0]  ev_pol,
    output logic                      mem_ren,
    output logic [X_BITS+Y_BITS-1:0]  mem_raddr1,
    output logic [X_BITS+Y_BITS-1:0]  mem_raddr2,
    input  logic [WORD_SIZE-1:0]      mem_rdata1,
    input  logic [WORD_SIZE-1:0]      mem_rdata2,
    output logic                      mem_wen,
    output logic [X_BITS+Y_BITS-1:0]  mem_waddr,
    output logic [WORD_SIZE-1:0]      mem_wdata,
    output logic [WORD_SIZE-1:0]      read_data1,
    output logic [WORD_SIZE-1:0]      read_data2,
    output logic [1:0]                pix_valid,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [TIMESTAMP_BITS-1:0] ts_tau_diff,
    output logic [TIMESTAMP_BITS-1:0] current_timestamp
);
    localparam int S   = 2 * RADIUS + 1;
    localparam int N   = S * S;
    localparam int NB  = (N + 1) / 2;
    localparam int KW  = $clog2(NB + 1);
    localparam int OW  = $clog2(RADIUS + 1) + 2;
    localparam int CXW = ((X_BITS > OW) ? X_BITS : OW) + 2;
    localparam int CYW = ((Y_BITS > OW) ? Y_BITS : OW) + 2;
    localparam int AW  = X_BITS + Y_BITS;

    localparam logic [KW-1:0]             LAST_K = KW'(NB - 1);
    localparam logic signed [OW-1:0]      RS     = OW'(RADIUS);
    localparam logic signed [OW-1:0]      SS     = OW'(S);
    localparam logic signed [OW-1:0]      ONE    = OW'(1);
    localparam logic signed [OW-1:0]      TWO    = OW'(2);
    localparam logic [TIMESTAMP_BITS-1:0] TAU_V  = TIMESTAMP_BITS'(TAU);

    // Handshake: an event transfers on a rising edge where ev_valid & ev_ready are both high;
    // ev_ready only depends on state and rst, never on ev_valid.
    typedef enum logic [1:0] {IDLE, READ, DRAIN_WR} state_t;
    state_t state, state_nxt;

    logic [X_BITS-1:0]         x_q;
    logic [Y_BITS-1:0]         y_q;
    logic [TIMESTAMP_BITS-1:0] ts_q;
    logic [POLARITY_BITS-1:0]  pol_q;
    logic [TIMESTAMP_BITS-1:0] tsd_q;
    logic [KW-1:0]             k;
    logic signed [OW-1:0]      dx1, dy1, dx2, dy2;
    logic                      ov_q, f1_q, f2_q, last_q;

    logic                      accept;
    logic                      last_beat;
    logic signed [OW-1:0]      dx1_sum, dx2_sum;
    logic signed [CXW-1:0]     cx1, cx2;
    logic signed [CYW-1:0]     cy1, cy2;
    logic                      v1, v2;
    logic [AW-1:0]             addr1, addr2;

    assign accept    = (state == IDLE) && ev_valid && !rst;
    assign last_beat = (k == LAST_K);

    // Neighbour coordinates as signed sums so edges never wrap into the far side.
    assign cx1 = CXW'($signed({1'b0, x_q})) + CXW'(dx1);
    assign cx2 = CXW'($signed({1'b0, x_q})) + CXW'(dx2);
    assign cy1 = CYW'($signed({1'b0, y_q})) + CYW'(dy1);
    assign cy2 = CYW'($signed({1'b0, y_q})) + CYW'(dy2);

    assign v1 = (cx1[CXW-1:X_BITS] == '0) && (cy1[CYW-1:Y_BITS] == '0);
    assign v2 = (cx2[CXW-1:X_BITS] == '0) && (cy2[CYW-1:Y_BITS] == '0) && !last_beat;

    assign addr1 = {cy1[Y_BITS-1:0], cx1[X_BITS-1:0]};
    assign addr2 = {cy2[Y_BITS-1:0], cx2[X_BITS-1:0]};

    assign dx1_sum = dx1 + TWO;
    assign dx2_sum = dx2 + TWO;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (ev_valid) state_nxt = READ;
            READ:     if (last_beat) state_nxt = DRAIN_WR;
            DRAIN_WR: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ev_ready   = 1'b0;
        mem_ren    = 1'b0;
        mem_raddr1 = '0;
        mem_raddr2 = '0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: ev_ready = !rst;
            READ: begin
                if (!rst) begin
                    mem_ren = 1'b1;
                    if (v1) mem_raddr1 = addr1;
                    if (v2) mem_raddr2 = addr2;
                end
            end
            DRAIN_WR: begin
                if (!rst) begin
                    mem_wen   = 1'b1;
                    mem_waddr = {y_q, x_q};
                    mem_wdata = {ts_q, pol_q};
                end
            end
            default: ;
        endcase
    end

    // Raster walk two pixels per beat; S >= 3 so a +2 step wraps at most one row.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            ts_q  <= '0;
            pol_q <= '0;
            tsd_q <= '0;
            k     <= '0;
            dx1   <= '0;
            dy1   <= '0;
            dx2   <= '0;
            dy2   <= '0;
        end else if (accept) begin
            x_q   <= ev_x;
            y_q   <= ev_y;
            ts_q  <= ev_ts;
            pol_q <= ev_pol;
            tsd_q <= (ev_ts >= TAU_V) ? ev_ts - TAU_V : '0;
            k     <= '0;
            dx1   <= -RS;
            dy1   <= -RS;
            dx2   <= -RS + ONE;
            dy2   <= -RS;
        end else if (state == READ) begin
            k <= k + KW'(1);
            if (dx1_sum > RS) begin
                dx1 <= dx1_sum - SS;
                dy1 <= dy1 + ONE;
            end else begin
                dx1 <= dx1_sum;
            end
            if (dx2_sum > RS) begin
                dx2 <= dx2_sum - SS;
                dy2 <= dy2 + ONE;
            end else begin
                dx2 <= dx2_sum;
            end
        end
    end

    // Flags follow the synchronous read by one cycle so they line up with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= 1'b0;
            f1_q   <= 1'b0;
            f2_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            ov_q   <= (state == READ);
            f1_q   <= (state == READ) && v1;
            f2_q   <= (state == READ) && v2;
            last_q <= (state == READ) && last_beat;
        end
    end

    assign out_valid         = ov_q;
    assign out_last          = last_q;
    assign pix_valid         = {f2_q, f1_q};
    assign read_data1        = f1_q ? mem_rdata1 : '0;
    assign read_data2        = f2_q ? mem_rdata2 : '0;
    assign ts_tau_diff       = tsd_q;
    assign current_timestamp = ts_q;
endmodule

// File: doc/patch_fetch.md
Name: patch_fetch

Overview:
Upstream feeder for the per-pixel age stage of the event-camera time-surface datapath. Accepts one event (x, y, ts, pol) at a time. Reads the (2R+1)x(2R+1) neighbourhood from the dual-read-port time-surface memory, two pixels per beat, and presents each word pair plus ts_tau_diff/current_timestamp to the age stage. It then writes the event's {ts, pol} back to the centre pixel.

Parameters:
TIMESTAMP_BITS, 16, width of a stored/event timestamp
POLARITY_BITS, 2, width of polarity field
WORD_SIZE, 18, memory word = {ts[TIMESTAMP_BITS-1:0], pol[POLARITY_BITS-1:0]}
X_BITS, 5, column coordinate width (sensor width 2^X_BITS)
Y_BITS, 5, row coordinate width (sensor height 2^Y_BITS)
RADIUS, 2, patch radius R; patch side S=2R+1, pixel count N=S*S (odd), beats NB=(N+1)/2
TAU, 32, time-window constant subtracted from event ts

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
ev_valid  in  1  event offered
ev_ready  out  1  block can accept event this cycle
ev_x  in  X_BITS  event column
ev_y  in  Y_BITS  event row
ev_ts  in  TIMESTAMP_BITS  event timestamp
ev_pol  in  POLARITY_BITS  event polarity
mem_ren  out  1  read enable for both read ports (1-cycle synchronous read latency)
mem_raddr1  out  X_BITS+Y_BITS  port-1 address = {row, col}
mem_raddr2  out  X_BITS+Y_BITS  port-2 address
mem_rdata1  in  WORD_SIZE  port-1 data, valid cycle after mem_ren
mem_rdata2  in  WORD_SIZE  port-2 data
mem_wen  out  1  write enable
mem_waddr  out  X_BITS+Y_BITS  write address
mem_wdata  out  WORD_SIZE  write data
read_data1  out  WORD_SIZE  slot-1 patch word to age stage
read_data2  out  WORD_SIZE  slot-2 patch word to age stage
pix_valid  out  2  bit0 = slot1 in-bounds, bit1 = slot2 in-bounds
out_valid  out  1  beat valid
out_last  out  1  final beat of patch
ts_tau_diff  out  TIMESTAMP_BITS  latched event ts minus TAU, floored at 0
current_timestamp  out  TIMESTAMP_BITS  latched event ts

Behaviour:
- FSM states: IDLE, READ, DRAIN_WR. ev_ready = (state==IDLE) & ~rst.
- Reset: state IDLE. Beat counter, pipeline flags, ts_tau_diff, current_timestamp all 0. Every output 0 except ev_ready, which is 1 from the first cycle after rst deasserts.
- Accept (IDLE, ev_valid&ev_ready), cycle 0:
  - latch x, y, ts, pol.
  - current_timestamp <= ev_ts.
  - ts_tau_diff <= (ev_ts >= TAU) ? ev_ts-TAU : 0; no wrap.
  - beat k <= 0; go READ.
- Pixel order: index p = 0..N-1 in raster order. dy = p/S - R, dx = p%S - R. Implement with incrementing dx/dy counters, no divider.
- READ, cycles 1..NB: beat k issues p=2k on port 1 and p=2k+1 on port 2; mem_ren=1.
  - A slot is invalid if x+dx or y+dy falls outside [0, 2^bits-1] (signed compare, no wrap), or if p >= N (last beat, slot 2).
  - Invalid slot: address 0, flag 0.
  - After beat NB-1 is issued, go DRAIN_WR.
- Output pipeline: slot flags and last flag delayed one cycle. Data beats appear on cycles 2..NB+1.
  - out_valid=1 on each data beat.
  - read_dataN = mem_rdataN when its flag is set, else 0.
  - pix_valid = delayed flags.
  - out_last=1 only on the beat for k=NB-1.
  - No backpressure: consumer accepts every beat.
- DRAIN_WR (cycle NB+1): final beat is output; mem_wen=1, mem_waddr={y,x}, mem_wdata={ts,pol}; next state IDLE.
  - The centre pixel therefore reads its old value (read-before-write).
- Event spacing: next accept earliest at cycle NB+2 (15 for R=2). ts_tau_diff/current_timestamp hold until the next accept.
- ev_valid while busy: ignored; no latch.
- rst in any state: aborts immediately; no mem_wen issued; pending beats discarded; out_valid 0 next cycle.
- Out-of-range RADIUS: N must fit memory; no runtime check.

Test Plan:
- Centre event x=16,y=16,ts=100,pol=1, TAU=32, R=2 -> ts_tau_diff=68, current_timestamp=100. Beat0 raddr1=462, raddr2=463. 13 out_valid beats on cycles 2..14, all pix_valid=11 except last=01 with read_data2=0, out_last on cycle 14 only. mem_wen on cycle 14, waddr=528, wdata=18'h00191.
- Corner event x=0,y=0 -> beats 0..5 pix_valid=00 with read_data=0; beat 6 pix_valid=11 (p=12,13 -> addr 0,1). Exactly 9 valid slots total; write to addr 0.
- ts=10 -> ts_tau_diff=0; ts=32 -> 0; ts=33 -> 1; ts=16'hFFFF -> 16'hFFDF.
- ev_valid held high with two events -> ev_ready low cycles 1..14, second accepted cycle 15. ev_x changes while busy have no effect.
- rst pulse during READ beat 5 -> next cycle out_valid=0, mem_ren=0. No mem_wen for that event; ev_ready=1 the cycle after rst drops.
- Two events at same pixel (5,7), ts=200 then ts=300 -> second patch's centre slot (beat 6 slot1) returns 18'h00320|pol1, i.e. first event's {ts,pol}.
